// File: rtl/frac_clk_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
// Rate math: f_ce = inc * f_clkin / 2^ACC_W.
package frac_clk_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int LOCK_CNT_W = 4;
    localparam logic [ACC_W_DEF-1:0] DEF_INC = 24'd621378;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rounded increment for an elaboration-time target rate.
    function automatic longint unsigned inc_for(
        input longint unsigned f_out_hz,
        input longint unsigned f_in_hz,
        input int unsigned acc_w = ACC_W_DEF
    );
        return ((f_out_hz << acc_w) + f_in_hz / 2) / f_in_hz;
    endfunction

endpackage

// File: rtl/frac_clk_gen_if.sv
// Configuration channel: one {ch,inc,en} beat per valid/ready transfer.
interface frac_clk_gen_if
    import frac_clk_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ACC_W = ACC_W_DEF
);
    localparam int CH_W = ch_w(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_inc, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_inc, cfg_en,
        output cfg_ready
    );

endinterface

// File: rtl/frac_clk_chan.sv
// One channel: phase accumulator, toggle output, lock counter and
// the rules deciding when a pending update may take effect.
module frac_clk_chan
    import frac_clk_pkg::*;
#(
    parameter int               ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEF_INC  = ACC_W'(frac_clk_pkg::DEF_INC),
    parameter logic             DEF_EN   = 1'b1,
    parameter int               LOCK_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pend_i,
    input  logic [ACC_W-1:0] pend_inc_i,
    input  logic             pend_en_i,
    output logic             apply_o,
    output logic             ce_o,
    output logic             clk_o,
    output logic             locked_o
);
    localparam logic [LOCK_CNT_W-1:0] LOCK_N = LOCK_CNT_W'(LOCK_CYC);

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      inc_q, inc_d;
    logic                  en_q, en_d;
    logic                  ce_q, ce_d;
    logic                  tgl_q, tgl_d;
    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  lock_q, lock_d;

    logic [ACC_W:0] sum;
    logic           carry;
    logic           apply;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        carry = en_q && sum[ACC_W];

        // A frozen (inc=0) channel has no carry to wait for.
        apply = 1'b0;
        if (pend_i) begin
            if (!en_q || inc_q == '0) apply = 1'b1;
            else if (pend_en_i)       apply = carry;
            else                      apply = !tgl_q && !ce_q && !carry;
        end

        acc_d = acc_q;
        inc_d = inc_q;
        en_d  = en_q;
        ce_d  = ce_q;
        tgl_d = tgl_q;
        cnt_d = cnt_q;

        if (en_q) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = carry;
            tgl_d = tgl_q ^ ce_q;
            if (carry && cnt_q != LOCK_N) cnt_d = cnt_q + 1'b1;
        end

        // Carry on the apply cycle is still emitted; new inc starts next add.
        if (apply) begin
            inc_d = pend_inc_i;
            en_d  = pend_en_i;
            cnt_d = '0;
            if (!pend_en_i) begin
                acc_d = '0;
                ce_d  = 1'b0;
                tgl_d = 1'b0;
            end else if (!en_q) begin
                acc_d = '0;
            end
        end

        lock_d = en_d && (inc_d != '0) && (cnt_d == LOCK_N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= DEF_INC;
            en_q   <= DEF_EN;
            ce_q   <= 1'b0;
            tgl_q  <= 1'b0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            en_q   <= en_d;
            ce_q   <= ce_d;
            tgl_q  <= tgl_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign apply_o  = apply;
    assign ce_o     = ce_q;
    assign clk_o    = tgl_q;
    assign locked_o = lock_q;

endmodule

// File: rtl/frac_clk_gen.sv
// N-channel fractional clock-enable generator with a single shadow
// configuration slot shared by all channels.
module frac_clk_gen
    import frac_clk_pkg::*;
#(
    parameter int               NCH      = 4,
    parameter int               ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEF_INC  = ACC_W'(frac_clk_pkg::DEF_INC),
    parameter logic [NCH-1:0]   DEF_EN   = {NCH{1'b1}},
    parameter int               LOCK_CYC = 4
) (
    input  logic           clkin,
    input  logic           rst_n,
    frac_clk_gen_if.slave  cfg,
    output logic [NCH-1:0] ce_o,
    output logic [NCH-1:0] clk_o,
    output logic [NCH-1:0] locked_o
);
    localparam int CH_W  = ch_w(NCH);
    localparam int NSLOT = 1 << CH_W;

    logic             slot_vld_q, slot_vld_d;
    logic [CH_W-1:0]  slot_ch_q, slot_ch_d;
    logic [ACC_W-1:0] slot_inc_q, slot_inc_d;
    logic             slot_en_q, slot_en_d;

    logic [NSLOT-1:0] done_vec;
    logic             accept;
    logic             slot_done;

    assign cfg.cfg_ready = !slot_vld_q;

    always_comb begin
        accept     = cfg.cfg_valid && !slot_vld_q;
        slot_done  = slot_vld_q && done_vec[slot_ch_q];
        slot_vld_d = slot_vld_q;
        slot_ch_d  = slot_ch_q;
        slot_inc_d = slot_inc_q;
        slot_en_d  = slot_en_q;
        if (slot_done) slot_vld_d = 1'b0;
        if (accept) begin
            slot_vld_d = 1'b1;
            slot_ch_d  = cfg.cfg_ch;
            slot_inc_d = cfg.cfg_inc;
            slot_en_d  = cfg.cfg_en;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 1'b0;
            slot_ch_q  <= '0;
            slot_inc_q <= '0;
            slot_en_q  <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_ch_q  <= slot_ch_d;
            slot_inc_q <= slot_inc_d;
            slot_en_q  <= slot_en_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        frac_clk_chan #(
            .ACC_W    (ACC_W),
            .DEF_INC  (DEF_INC),
            .DEF_EN   (DEF_EN[i]),
            .LOCK_CYC (LOCK_CYC)
        ) u_chan (
            .clk        (clkin),
            .rst_n      (rst_n),
            .pend_i     (slot_vld_q && slot_ch_q == CH_W'(i)),
            .pend_inc_i (slot_inc_q),
            .pend_en_i  (slot_en_q),
            .apply_o    (done_vec[i]),
            .ce_o       (ce_o[i]),
            .clk_o      (clk_o[i]),
            .locked_o   (locked_o[i])
        );
    end

    // Beats aimed at nonexistent channels retire immediately.
    if (NSLOT > NCH) begin : g_pad
        assign done_vec[NSLOT-1:NCH] = '1;
    end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Directed bench: ACC_W=8, NCH=2, DEF_INC=64, LOCK_CYC=4.
// Cycle k = state sampled 1 time unit after the k-th edge since reset release.
module tb_frac_clk_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] ce;
    logic [1:0] clko;
    logic [1:0] lk;
    int         cyc;
    int         checks;
    int         failures;

    frac_clk_gen_if #(.NCH(2), .ACC_W(8)) cfg_if ();

    frac_clk_gen #(
        .NCH      (2),
        .ACC_W    (8),
        .DEF_INC  (8'd64),
        .DEF_EN   (2'b11),
        .LOCK_CYC (4)
    ) dut (
        .clkin    (clk),
        .rst_n    (rst_n),
        .cfg      (cfg_if.slave),
        .ce_o     (ce),
        .clk_o    (clko),
        .locked_o (lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic send(input logic ch, input logic [7:0] inc,
                        input logic en);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_inc   = inc;
        cfg_if.cfg_en    = en;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 1'b0;
        cfg_if.cfg_inc   = 8'd0;
        cfg_if.cfg_en    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce", ce, 2'b00);
        chk("rst_clk", clko, 2'b00);
        chk("rst_lock", lk, 2'b00);
        chk("rst_rdy", {1'b0, cfg_if.cfg_ready}, 2'b01);

        rst_n = 1'b1;
        cyc   = 0;
        goto(3);  chk("ce_c3", ce, 2'b00);
        goto(4);  chk("ce_c4", ce, 2'b11);
        goto(5);  chk("ce_c5", ce, 2'b00);
        chk("clk_c5", clko, 2'b11);
        goto(9);  chk("clk_c9", clko, 2'b00);
        goto(15); chk("lock_c15", lk, 2'b00);
        goto(16); chk("lock_c16", lk, 2'b11);

        // ch0 -> inc 128 mid-period
        goto(17); send(1'b0, 8'd128, 1'b1);
        goto(18); cfg_if.cfg_valid = 1'b0;
        chk("rdy_c18", {1'b0, cfg_if.cfg_ready}, 2'b00);
        goto(19); chk("lock_c19", lk, 2'b11);
        chk("rdy_c19", {1'b0, cfg_if.cfg_ready}, 2'b00);
        chk("ce_c19", ce, 2'b00);
        goto(20); chk("ce_c20", ce, 2'b11);
        chk("lock_c20", lk, 2'b10);
        chk("rdy_c20", {1'b0, cfg_if.cfg_ready}, 2'b01);
        goto(21); chk("ce_c21", ce, 2'b00);
        goto(22); chk("ce_c22", ce, 2'b01);
        goto(23); chk("clk_c23", clko, 2'b10);
        goto(27); chk("lock_c27", lk, 2'b10);
        goto(28); chk("lock_c28", lk, 2'b11);

        // ch1 disable while its clock is high
        goto(29); chk("clk1_c29", {1'b0, clko[1]}, 2'b01);
        send(1'b1, 8'd64, 1'b0);
        goto(30); cfg_if.cfg_valid = 1'b0;
        goto(32); chk("clk1_c32", {1'b0, clko[1]}, 2'b01);
        chk("rdy_c32", {1'b0, cfg_if.cfg_ready}, 2'b00);
        goto(33); chk("clk1_c33", {1'b0, clko[1]}, 2'b00);
        chk("rdy_c33", {1'b0, cfg_if.cfg_ready}, 2'b00);
        chk("lock_c33", lk, 2'b11);
        goto(34); chk("rdy_c34", {1'b0, cfg_if.cfg_ready}, 2'b01);
        chk("lock_c34", lk, 2'b01);
        goto(36); chk("ce_c36", ce, 2'b01);
        chk("clk1_c36", {1'b0, clko[1]}, 2'b00);

        // ch1 enable from disabled, inc=3
        send(1'b1, 8'd3, 1'b1);
        goto(37); cfg_if.cfg_valid = 1'b0;
        chk("rdy_c37", {1'b0, cfg_if.cfg_ready}, 2'b00);
        goto(38); chk("rdy_c38", {1'b0, cfg_if.cfg_ready}, 2'b01);
        goto(123); chk("ce1_c123", {1'b0, ce[1]}, 2'b00);
        goto(124); chk("ce_c124", ce, 2'b11);
        goto(208); chk("ce1_c208", {1'b0, ce[1]}, 2'b00);
        goto(209); chk("ce_c209", ce, 2'b10);
        goto(294); chk("ce_c294", ce, 2'b11);
        chk("lock_c294", lk, 2'b01);
        goto(379); chk("ce1_c379", {1'b0, ce[1]}, 2'b00);
        goto(380); chk("ce_c380", ce, 2'b11);
        chk("lock_c380", lk, 2'b11);

        // back-to-back beats on ch0: inc 64 then inc 128
        send(1'b0, 8'd64, 1'b1);
        goto(381); chk("rdy_c381", {1'b0, cfg_if.cfg_ready}, 2'b00);
        send(1'b0, 8'd128, 1'b1);
        goto(382); chk("rdy_c382", {1'b0, cfg_if.cfg_ready}, 2'b01);
        chk("lock_c382", lk, 2'b10);
        chk("ce_c382", ce, 2'b01);
        goto(383); chk("rdy_c383", {1'b0, cfg_if.cfg_ready}, 2'b00);
        cfg_if.cfg_valid = 1'b0;
        goto(384); chk("ce_c384", ce, 2'b00);
        goto(385); chk("rdy_c385", {1'b0, cfg_if.cfg_ready}, 2'b00);
        goto(386); chk("ce_c386", ce, 2'b01);
        chk("rdy_c386", {1'b0, cfg_if.cfg_ready}, 2'b01);
        goto(388); chk("ce_c388", ce, 2'b01);

        // reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ce", ce, 2'b00);
        chk("mrst_clk", clko, 2'b00);
        chk("mrst_lock", lk, 2'b00);
        chk("mrst_rdy", {1'b0, cfg_if.cfg_ready}, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        goto(3); chk("rce_c3", ce, 2'b00);
        goto(4); chk("rce_c4", ce, 2'b11);
        goto(6); chk("rce_c6", ce, 2'b00);
        goto(8); chk("rce_c8", ce, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
